// File: rtl/smi_rx_stream_mux_if.sv
// smi_rx_stream_mux_if: FIFO pull and SMI read bus bundle for smi_rx_stream_mux
// Optional macro: SMI_TEST_PATTERN_EN adds smi_test.
// Ports (slave view, DUT side):
//   fifo_empty   in   NUM_CH         per-channel FIFO empty
//   fifo_pull    out  NUM_CH         per-channel pull pulse
//   fifo_data    in   NUM_CH*WORD_W  pulled words, channel c at [c*WORD_W +: WORD_W]
//   smi_ch       in   CH_W           channel select
//   smi_soe_se   in   1              asynchronous SMI read strobe, active-low
//   smi_data_out out  DATA_W         SMI read data
//   smi_read_req out  1              data-available request
//   smi_test     in   1              test pattern enable (SMI_TEST_PATTERN_EN only)
interface smi_rx_stream_mux_if #(
    parameter int NUM_CH = 2,
    parameter int WORD_W = 32,
    parameter int DATA_W = 8,
    parameter int CH_W   = 1
);
    logic [NUM_CH-1:0]        fifo_empty;
    logic [NUM_CH-1:0]        fifo_pull;
    logic [NUM_CH*WORD_W-1:0] fifo_data;
    logic [CH_W-1:0]          smi_ch;
    logic                     smi_soe_se;
    logic [DATA_W-1:0]        smi_data_out;
    logic                     smi_read_req;
`ifdef SMI_TEST_PATTERN_EN
    logic                     smi_test;
    modport master (output fifo_empty, fifo_data, smi_ch, smi_soe_se, smi_test,
                    input fifo_pull, smi_data_out, smi_read_req);
    modport slave (input fifo_empty, fifo_data, smi_ch, smi_soe_se, smi_test,
                   output fifo_pull, smi_data_out, smi_read_req);
`else
    modport master (output fifo_empty, fifo_data, smi_ch, smi_soe_se,
                    input fifo_pull, smi_data_out, smi_read_req);
    modport slave (input fifo_empty, fifo_data, smi_ch, smi_soe_se,
                   output fifo_pull, smi_data_out, smi_read_req);
`endif
endinterface

// File: rtl/smi_rx_stream_mux.sv
// smi_rx_stream_mux: serialises per-channel FIFO words MSB-first onto the SMI read bus
// Optional macro: SMI_TEST_PATTERN_EN replaces beat data with an LFSR pattern.
// Ports:
//   i_sys_clk    in   1       system clock
//   i_rst        in   1       synchronous reset, active-high
//   i_ioc        in   5       register index
//   i_cs         in   1       module select
//   i_fetch_cmd  in   1       register read strobe
//   o_data_out   out  8       register read data
//   o_underrun   out  NUM_CH  sticky per-channel underrun flags
//   bus          slave        FIFO pull and SMI bus (smi_rx_stream_mux_if)
module smi_rx_stream_mux #(
    parameter int              NUM_CH         = 2,
    parameter int              WORD_W         = 32,
    parameter int              DATA_W         = 8,
    parameter int              CH_W           = 1,
    parameter logic [DATA_W-1:0] UNDERRUN_FILL = '0,
    parameter logic [7:0]      MODULE_VERSION = 8'h02
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic [4:0]        i_ioc,
    input  logic              i_cs,
    input  logic              i_fetch_cmd,
    output logic [7:0]        o_data_out,
    output logic [NUM_CH-1:0] o_underrun,
    smi_rx_stream_mux_if.slave bus
);
    localparam int BEATS = WORD_W / DATA_W;
    localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    typedef enum logic [1:0] {EMPTY, REQ, LOADED} state_t;
    state_t                       r_state [NUM_CH];
    logic [CNT_W-1:0]             r_cnt [NUM_CH];
    logic [BEATS-1:0][DATA_W-1:0] r_word [NUM_CH];
    logic                         r_s1, r_s2, r_s3;
    logic [NUM_CH-1:0]            r_und, w_loaded, w_idle, w_hit, w_und_set;
    logic                         w_beat, w_test, w_take, w_ch_ok, w_sel_loaded, w_fetch;
    logic [CH_W-1:0]              w_sel;
    logic [DATA_W-1:0]            w_beat_data, w_lfsr_out;
    logic [7:0]                   w_status;

    assign w_beat  = r_s3 & ~r_s2;
    assign w_take  = w_beat & ~w_test;
    assign w_fetch = i_cs & i_fetch_cmd;
    assign w_ch_ok = 32'(bus.smi_ch) < NUM_CH;
    assign w_sel   = w_ch_ok ? bus.smi_ch : '0;
    assign w_hit   = w_take && w_ch_ok ? NUM_CH'(1) << w_sel : '0;
    assign w_sel_loaded = w_ch_ok && r_state[w_sel] == LOADED;
    assign w_beat_data  = w_test ? w_lfsr_out :
                          w_sel_loaded ? r_word[w_sel][CNT_W'(BEATS-1) - r_cnt[w_sel]] : UNDERRUN_FILL;
    assign w_und_set = w_hit & ~w_loaded;
    assign w_status  = (8'(w_loaded) << 4) | 8'(bus.fifo_empty);
    assign o_underrun = r_und;
    // Pull is asserted in the EMPTY cycle so the FIFO's 1-cycle read data lands during REQ.
    assign bus.fifo_pull = i_rst ? '0 : w_idle & ~bus.fifo_empty;

`ifdef SMI_TEST_PATTERN_EN
    localparam logic [DATA_W-1:0] SEED = DATA_W'(8'h56);
    logic [DATA_W-1:0] r_lfsr;
    assign w_test = bus.smi_test;
    // An all-zero state would lock up; it is replaced by the seed before use.
    assign w_lfsr_out = r_lfsr == '0 ? SEED : r_lfsr;
    always_ff @(posedge i_sys_clk) begin
        if (i_rst)
            r_lfsr <= SEED;
        else if (w_beat && w_test)
            r_lfsr <= {w_lfsr_out[2] ^ w_lfsr_out[3], w_lfsr_out[DATA_W-1:1]};
    end
`else
    assign w_test     = 1'b0;
    assign w_lfsr_out = '0;
`endif

    always_comb begin
        w_loaded = '0;
        w_idle   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_loaded[c] = r_state[c] == LOADED;
            w_idle[c]   = r_state[c] == EMPTY;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_rst) begin
                r_state[c] <= EMPTY;
                r_cnt[c]   <= '0;
            end else if (r_state[c] == EMPTY) begin
                if (!bus.fifo_empty[c])
                    r_state[c] <= REQ;
            end else if (r_state[c] == REQ) begin
                r_state[c] <= LOADED;
                r_word[c]  <= bus.fifo_data[c*WORD_W +: WORD_W];
                r_cnt[c]   <= '0;
            end else if (w_hit[c]) begin
                r_cnt[c]   <= r_cnt[c] == CNT_W'(BEATS-1) ? '0 : r_cnt[c] + CNT_W'(1);
                r_state[c] <= r_cnt[c] == CNT_W'(BEATS-1) ? EMPTY : LOADED;
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            {r_s1, r_s2, r_s3} <= 3'b111;
            bus.smi_data_out   <= '0;
            bus.smi_read_req   <= 1'b0;
            r_und              <= '0;
            o_data_out         <= '0;
        end else begin
            {r_s1, r_s2, r_s3} <= {bus.smi_soe_se, r_s1, r_s2};
            if (w_beat)
                bus.smi_data_out <= w_beat_data;
            bus.smi_read_req <= w_test | (|(w_loaded | ~bus.fifo_empty));
            // A new underrun in the clearing cycle survives the read-to-clear.
            r_und <= (w_fetch && i_ioc == 5'd2 ? '0 : r_und) | w_und_set;
            if (w_fetch)
                o_data_out <= i_ioc == 5'd0 ? MODULE_VERSION :
                              i_ioc == 5'd1 ? w_status :
                              i_ioc == 5'd2 ? 8'(r_und) : o_data_out;
        end
    end
endmodule
